// File: rtl/pipe_ex_pkg.sv
// Shared constants and clamping arithmetic for the pipe_ex datapath.
// The sat_* helpers are only referenced when PIPE_EX_SAT_EN is defined.
package pipe_ex_pkg;

  localparam int PIPE_EX_W    = 10;
  localparam int PIPE_EX_MAXW = 32;

  typedef logic [PIPE_EX_MAXW-1:0] word_t;
  typedef logic [PIPE_EX_MAXW:0]   wide_t;
  typedef logic [2*PIPE_EX_MAXW-1:0] prod_t;

  function automatic word_t sat_max(input int n);
    wide_t m;
    m = ((PIPE_EX_MAXW+1)'(1) << n) - (PIPE_EX_MAXW+1)'(1);
    return m[PIPE_EX_MAXW-1:0];
  endfunction

  function automatic word_t sat_add(
    input word_t a,
    input word_t b,
    input int    n
  );
    wide_t s;
    word_t m;
    m = sat_max(n);
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, m}) ? m : s[PIPE_EX_MAXW-1:0];
  endfunction

  function automatic word_t sat_sub(
    input word_t a,
    input word_t b
  );
    return (a < b) ? '0 : (a - b);
  endfunction

  function automatic word_t sat_mul(
    input word_t a,
    input word_t b,
    input int    n
  );
    prod_t p;
    word_t m;
    m = sat_max(n);
    p = {{PIPE_EX_MAXW{1'b0}}, a} * {{PIPE_EX_MAXW{1'b0}}, b};
    return (p > {{PIPE_EX_MAXW{1'b0}}, m}) ? m : p[PIPE_EX_MAXW-1:0];
  endfunction

endpackage

// File: rtl/pipe_ex_reg.sv
// N-bit pipeline register with asynchronous active-high clear.
module pipe_ex_reg #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/pipe_ex.sv
// Three-stage pipeline computing F = (A + B + (C - D)) * D.
// Define PIPE_EX_SAT_EN to clamp every stage instead of wrapping.
module pipe_ex
  import pipe_ex_pkg::*;
#(
  parameter int N = PIPE_EX_W
) (
  output logic [N-1:0] F,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  input  logic         clk,
  input  logic         rst
);

  logic [N-1:0] x1, x2, d1, x3, d2;
  logic [N-1:0] x1_n, x2_n, x3_n, f_n;

`ifdef PIPE_EX_SAT_EN
  // Operands are zero-extended into the package word, clamped, then narrowed.
  always_comb begin
    x1_n = N'(sat_add(word_t'(A), word_t'(B), N));
    x2_n = N'(sat_sub(word_t'(C), word_t'(D)));
    x3_n = N'(sat_add(word_t'(x1), word_t'(x2), N));
    f_n  = N'(sat_mul(word_t'(x3), word_t'(d2), N));
  end
`else
  always_comb begin
    x1_n = A + B;
    x2_n = C - D;
    x3_n = x1 + x2;
    f_n  = x3 * d2;
  end
`endif

  pipe_ex_reg #(.N(N)) u_x1 (
    .clk (clk),
    .rst (rst),
    .d   (x1_n),
    .q   (x1)
  );

  pipe_ex_reg #(.N(N)) u_x2 (
    .clk (clk),
    .rst (rst),
    .d   (x2_n),
    .q   (x2)
  );

  pipe_ex_reg #(.N(N)) u_d1 (
    .clk (clk),
    .rst (rst),
    .d   (D),
    .q   (d1)
  );

  pipe_ex_reg #(.N(N)) u_x3 (
    .clk (clk),
    .rst (rst),
    .d   (x3_n),
    .q   (x3)
  );

  pipe_ex_reg #(.N(N)) u_d2 (
    .clk (clk),
    .rst (rst),
    .d   (d1),
    .q   (d2)
  );

  pipe_ex_reg #(.N(N)) u_f (
    .clk (clk),
    .rst (rst),
    .d   (f_n),
    .q   (F)
  );

endmodule

// File: tb/tb_pipe_ex.sv
// Scoreboard bench for pipe_ex: driver queues expected F per edge,
// monitor pops and compares entries as their edge comes due.
module tb_pipe_ex;

  localparam int N = 10;

`ifdef PIPE_EX_SAT_EN
  localparam int EW1 = 124;
  localparam int EW2 = 124;
  localparam int EOV = 1023;
`else
  localparam int EW1 = 112;
  localparam int EW2 = 116;
  localparam int EOV = 660;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] a, b, c, d;
  logic [N-1:0] f;

  typedef struct {
    int           due;
    logic [N-1:0] val;
    string        name;
  } exp_t;

  exp_t sbq[$];
  int   edge_n;
  int   checks;
  int   errors;

  pipe_ex #(.N(N)) dut (
    .F   (f),
    .A   (a),
    .B   (b),
    .C   (c),
    .D   (d),
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  always @(posedge clk) begin
    #1;
    while (sbq.size() > 0 && sbq[0].due <= edge_n) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (e.due != edge_n) begin
        errors++;
        $display("FAIL %s: missed due edge %0d (now %0d)", e.name, e.due, edge_n);
      end else if (f !== e.val) begin
        errors++;
        $display("FAIL %s: F=%0d expected %0d at edge %0d",
                 e.name, f, e.val, edge_n);
      end
    end
  end

  task automatic push(input int due, input int v, input string nm);
    exp_t e;
    e.due  = due;
    e.val  = v[N-1:0];
    e.name = nm;
    sbq.push_back(e);
  endtask

  // Drive one operand set; it is sampled at edge_n+1 and lands on F at edge_n+3.
  task automatic issue(input int ia, input int ib, input int ic, input int id,
                       input int fexp, input string nm);
    @(negedge clk);
    a = ia[N-1:0];
    b = ib[N-1:0];
    c = ic[N-1:0];
    d = id[N-1:0];
    push(edge_n + 3, fexp, nm);
  endtask

  task automatic direct(input int v, input string nm);
    checks++;
    if (f !== v[N-1:0]) begin
      errors++;
      $display("FAIL %s: F=%0d expected %0d", nm, f, v);
    end
  endtask

  int seq1[6][5] = '{
    '{10, 12,  6, 3, 75},
    '{10, 10,  5, 3, 66},
    '{15, 10,  8, 2, 62},
    '{ 8, 15,  5, 0,  0},
    '{10, 20,  5, 3, 96},
    '{10, 10, 30, 1, 49}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a = '0;
    b = '0;
    c = '0;
    d = '0;
    #2;
    direct(0, "reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      issue(seq1[i][0], seq1[i][1], seq1[i][2], seq1[i][3], seq1[i][4],
            $sformatf("seq1_%0d", i));

    issue( 20,  11,   1,  4, EW1, "wrap_sub_1");
    issue( 30,   1,   2,  4, EW2, "wrap_sub_2");
    issue(500, 500, 100, 10, EOV, "overflow");

    // Hold: same set for several edges with glitches between edges.
    for (int i = 0; i < 4; i++) begin
      issue(10, 12, 6, 3, 75, $sformatf("hold_%0d", i));
      @(posedge clk);
      #2;
      a = 10'd999;
      c = 10'd0;
    end
    @(negedge clk);
    a = 10'd10;
    c = 10'd6;
    repeat (3) @(posedge clk);
    #2;
    direct(75, "hold_stable");

    // Refill with non-zero data, then reset between edges.
    issue(15, 10, 8, 2, 62, "prefill_0");
    issue(10, 20, 5, 3, 96, "prefill_1");
    issue(10, 10, 30, 1, 49, "prefill_2");
    @(posedge clk);
    #3;
    direct(62, "prefill_f");
    sbq.delete();
    rst = 1'b1;
    #1;
    direct(0, "async_reset");
    repeat (2) @(posedge clk);
    #1;
    direct(0, "reset_held");

    @(negedge clk);
    rst = 1'b0;
    push(edge_n + 1, 0, "post_rst_z1");
    push(edge_n + 2, 0, "post_rst_z2");
    a = 10'd10;
    b = 10'd12;
    c = 10'd6;
    d = 10'd3;
    push(edge_n + 3, 75, "post_rst_first");
    issue(10, 10, 5, 3, 66, "post_rst_second");

    for (int i = 0; i < 8 && sbq.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
